// File: rtl/inband_reg_bank_if.sv
// ============================================================================
// Module      : inband_reg_bank_if
// Description : Request/response handshake bundle for the inband register bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inband_reg_bank_if #(
    parameter int DW = 32,
    parameter int AW = 7
);
    logic              req_valid;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_data;
    logic [DW/8-1:0]   req_be;
    logic              req_ready;
    logic              resp_valid;
    logic [DW-1:0]     resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_data, req_be,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, req_be,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

`default_nettype wire

// File: rtl/inband_reg_bank.sv
// ============================================================================
// Module      : inband_reg_bank
// Description : Register-access engine: RO status bundle reads, byte-masked
//               local registers, setting-bus write mirror, registered responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inband_reg_bank #(
    parameter int            DW         = 32,
    parameter int            AW         = 7,
    parameter int            NUM_RO     = 44,
    parameter int            LOCAL_BASE = 50,
    parameter int            NUM_LOCAL  = 8,
    parameter logic [DW-1:0] RESET_VAL  = '0
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    inband_reg_bank_if.slave             bus,
    input  wire logic [NUM_RO*DW-1:0]    ro_bundle,
    output logic [NUM_LOCAL*DW-1:0]      local_regs,
    output logic [AW-1:0]                addr_wr,
    output logic [DW-1:0]                data_wr,
    output logic                         strobe_wr,
    output logic [15:0]                  debugbus
);

    localparam int       c_NB     = DW / 8;
    localparam logic     S_IDLE   = 1'b0;
    localparam logic     S_BUSY   = 1'b1;

    logic                r_state;
    logic                w_state_nxt;
    logic                w_ready;
    logic                w_accept;

    logic                w_ro_hit;
    logic [DW-1:0]       w_ro_word;
    logic [NUM_LOCAL-1:0] w_loc_hit;
    logic [DW-1:0]       w_loc_word;

    logic                r_resp_valid;
    logic [DW-1:0]       r_resp_data;
    logic                r_resp_err;
    logic                r_strobe;
    logic [AW-1:0]       r_addr_wr;
    logic [DW-1:0]       r_data_wr;

    logic [DW-1:0]       r_local [NUM_LOCAL];

    assign w_accept = bus.req_valid & w_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (r_state == S_IDLE);
    end

    // Address decode: one-hot compare against every mapped word.
    always_comb begin
        w_ro_hit   = 1'b0;
        w_ro_word  = '0;
        w_loc_hit  = '0;
        w_loc_word = '0;
        for (int i = 0; i < NUM_RO; i++) begin
            if (bus.req_addr == AW'(i)) begin
                w_ro_hit  = 1'b1;
                w_ro_word = ro_bundle[i*DW +: DW];
            end
        end
        for (int i = 0; i < NUM_LOCAL; i++) begin
            if (bus.req_addr == AW'(LOCAL_BASE + i)) begin
                w_loc_hit[i] = 1'b1;
                w_loc_word   = r_local[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_strobe     <= 1'b0;
            r_addr_wr    <= '0;
            r_data_wr    <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_strobe     <= 1'b0;
            if (w_accept) begin
                r_resp_valid <= 1'b1;
                if (bus.req_write) begin
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b0;
                    r_strobe    <= 1'b1;
                    r_addr_wr   <= bus.req_addr;
                    r_data_wr   <= bus.req_data;
                end else if (w_ro_hit) begin
                    r_resp_data <= w_ro_word;
                    r_resp_err  <= 1'b0;
                end else if (|w_loc_hit) begin
                    r_resp_data <= w_loc_word;
                    r_resp_err  <= 1'b0;
                end else begin
                    r_resp_data <= '1;
                    r_resp_err  <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LOCAL; gi++) begin : g_local
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_local[gi] <= RESET_VAL;
                end else if (w_accept && bus.req_write && w_loc_hit[gi]) begin
                    for (int b = 0; b < c_NB; b++) begin
                        if (bus.req_be[b]) begin
                            r_local[gi][b*8 +: 8] <= bus.req_data[b*8 +: 8];
                        end
                    end
                end
            end
            assign local_regs[gi*DW +: DW] = r_local[gi];
        end
    endgenerate

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign addr_wr        = r_addr_wr;
    assign data_wr        = r_data_wr;
    assign strobe_wr      = r_strobe;

    assign debugbus = {r_state, bus.req_valid, w_ready, bus.req_write, r_resp_valid,
                       r_resp_err, r_strobe, r_addr_wr[2:0], r_data_wr[5:0]};

endmodule

`default_nettype wire

// File: tb/tb_inband_reg_bank.sv
// ============================================================================
// Module      : tb_inband_reg_bank
// Description : Randomized self-checking bench for inband_reg_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inband_reg_bank;

    localparam int DW         = 32;
    localparam int AW         = 7;
    localparam int NUM_RO     = 44;
    localparam int LOCAL_BASE = 50;
    localparam int NUM_LOCAL  = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_RO*DW-1:0]      ro_bundle;
    logic [NUM_LOCAL*DW-1:0]   local_regs;
    logic [AW-1:0]             addr_wr;
    logic [DW-1:0]             data_wr;
    logic                      strobe_wr;
    logic [15:0]               debugbus;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] m_ro  [NUM_RO];
    logic [DW-1:0] m_loc [NUM_LOCAL];

    inband_reg_bank_if #(.DW(DW), .AW(AW)) bus ();

    inband_reg_bank #(
        .DW(DW), .AW(AW), .NUM_RO(NUM_RO), .LOCAL_BASE(LOCAL_BASE),
        .NUM_LOCAL(NUM_LOCAL), .RESET_VAL('0)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ro_bundle  (ro_bundle),
        .local_regs (local_regs),
        .addr_wr    (addr_wr),
        .data_wr    (data_wr),
        .strobe_wr  (strobe_wr),
        .debugbus   (debugbus)
    );

    always #5 clk = ~clk;

    always_comb begin
        ro_bundle = '0;
        for (int i = 0; i < NUM_RO; i++) ro_bundle[i*DW +: DW] = m_ro[i];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_locals();
        for (int i = 0; i < NUM_LOCAL; i++)
            chk($sformatf("local[%0d]", i), 64'(local_regs[i*DW +: DW]), 64'(m_loc[i]));
    endtask

    // One request; returns mid-cycle T+1 with req_valid still asserted.
    task automatic do_req(input bit w, input int a, input logic [DW-1:0] d, input logic [3:0] be);
        logic [DW-1:0] ed;
        logic          ee;
        @(negedge clk);
        chk("ready_before", 64'(bus.req_ready), 64'd1);
        chk("resp_before", 64'(bus.resp_valid), 64'd0);
        chk("strobe_before", 64'(strobe_wr), 64'd0);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = AW'(a);
        bus.req_data  = d;
        bus.req_be    = be;
        ed = '0;
        ee = 1'b0;
        if (w) begin
            if (a >= LOCAL_BASE && a < LOCAL_BASE + NUM_LOCAL)
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_loc[a-LOCAL_BASE][b*8 +: 8] = d[b*8 +: 8];
        end else if (a < NUM_RO) begin
            ed = m_ro[a];
        end else if (a >= LOCAL_BASE && a < LOCAL_BASE + NUM_LOCAL) begin
            ed = m_loc[a-LOCAL_BASE];
        end else begin
            ed = '1;
            ee = 1'b1;
        end
        @(negedge clk);
        chk("resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("resp_data", 64'(bus.resp_data), 64'(ed));
        chk("resp_err", 64'(bus.resp_err), 64'(ee));
        chk("ready_busy", 64'(bus.req_ready), 64'd0);
        chk("strobe_wr", 64'(strobe_wr), 64'(w));
        if (w) begin
            chk("addr_wr", 64'(addr_wr), 64'(a));
            chk("data_wr", 64'(data_wr), 64'(d));
        end
        check_locals();
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("resp_after", 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        int a;
        for (int i = 0; i < NUM_RO; i++) m_ro[i] = $urandom;
        m_ro[2] = 32'h0000_0ABC;
        for (int i = 0; i < NUM_LOCAL; i++) m_loc[i] = '0;

        reset         = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 7'd51;
        bus.req_data  = 32'hFFFF_FFFF;
        bus.req_be    = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("rst_resp", 64'(bus.resp_valid), 64'd0);
            chk("rst_strobe", 64'(strobe_wr), 64'd0);
        end
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_addr_wr", 64'(addr_wr), 64'd0);
        chk("rst_data_wr", 64'(data_wr), 64'd0);
        check_locals();

        do_req(1'b0, 2, 32'h0, 4'h0);
        idle();
        do_req(1'b1, 51, 32'hDEAD_BEEF, 4'b0101);
        do_req(1'b0, 51, 32'h0, 4'h0);
        chk("byte_merge", 64'(local_regs[1*DW +: DW]), 64'h00AD_00EF);
        idle();
        do_req(1'b0, 45, 32'h0, 4'h0);
        idle();
        do_req(1'b0, 58, 32'h0, 4'h0);
        idle();

        for (int k = 0; k < 3; k++) begin
            do_req(1'b1, 50, 32'h1234_5678 + k, 4'hF);
            do_req(1'b0, 50, 32'h0, 4'h0);
        end
        idle();
        do_req(1'b1, 53, 32'hCAFE_F00D, 4'h0);
        idle();

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, NUM_RO - 1);
                1, 2:    a = $urandom_range(LOCAL_BASE, LOCAL_BASE + NUM_LOCAL - 1);
                default: a = $urandom_range(0, (1 << AW) - 1);
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) idle();
        end
        idle();

        do_req(1'b1, 52, 32'h5555_AAAA, 4'hF);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < NUM_LOCAL; i++) m_loc[i] = '0;
        @(negedge clk);
        chk("midrst_strobe", 64'(strobe_wr), 64'd0);
        chk("midrst_resp", 64'(bus.resp_valid), 64'd0);
        check_locals();
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(bus.req_ready), 64'd1);
        do_req(1'b0, 52, 32'h0, 4'h0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inband_reg_bank.md
Name: inband_reg_bank

Overview:
- Parametrised register-access engine for the inband control path.
- Serves read/write requests over a valid/ready handshake with registered responses:
  - reads from a flattened read-only status bundle;
  - reads and writes to NUM_LOCAL local setting registers with byte enables.
- Mirrors every write onto the setting bus (addr_wr/data_wr/strobe_wr) for external setting_reg instances.
- Successor to the combinational register read-back block: adds clocked responses, error reporting and byte-masked local storage.

Parameters:
- DW, 32, data width; multiple of 8.
- AW, 7, address width.
- NUM_RO, 44, number of read-only bundle words at addresses 0..NUM_RO-1.
- LOCAL_BASE, 50, first local register address. Requires LOCAL_BASE >= NUM_RO.
- NUM_LOCAL, 8, number of local registers. Requires LOCAL_BASE+NUM_LOCAL <= 2^AW.
- RESET_VAL, 0, reset value of every local register (DW bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  register address.
- req_data  in  DW  write data.
- req_be  in  DW/8  byte enables; affect local registers only.
- req_ready  out  1  engine can accept a request.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  DW  read data; 0 on write responses.
- resp_err  out  1  read from an unmapped address.
- ro_bundle  in  NUM_RO*DW  status words; word i = bits [i*DW +: DW].
- local_regs  out  NUM_LOCAL*DW  local register contents, flattened like ro_bundle.
- addr_wr  out  AW  setting-bus address.
- data_wr  out  DW  setting-bus data.
- strobe_wr  out  1  setting-bus write strobe.
- debugbus  out  16  debug visibility.

Behaviour:
- Reset (reset low at a clk edge):
  - state goes to IDLE; req_ready=1.
  - resp_valid=0, resp_data=0, resp_err=0.
  - strobe_wr=0, addr_wr=0, data_wr=0.
  - every local register is set to RESET_VAL.
  - Reset dominates: a request presented in a reset cycle is not accepted.
- FSM has two states, IDLE and BUSY.
  - req_ready = (state==IDLE).
  - Accept occurs when req_valid & req_ready at an edge; state then goes to BUSY.
  - BUSY always returns to IDLE at the next edge.
  - Maximum throughput is one request per 2 cycles.
- Read accepted in cycle T: in cycle T+1, resp_valid=1 and resp_data/resp_err are registered from the address at T.
  - addr < NUM_RO: data = ro_bundle word, err=0.
  - LOCAL_BASE <= addr < LOCAL_BASE+NUM_LOCAL: data = local register, err=0.
  - Any other address: data = all-ones, err=1.
- Write accepted in cycle T:
  - If the address is local, byte k of that register takes req_data byte k where req_be[k]=1; other bytes hold. The update is visible on local_regs from T+1.
  - A write to a non-local address does not change local storage.
  - In T+1 for every write: strobe_wr=1, addr_wr=req_addr, data_wr=req_data (raw, not byte-merged).
  - Also in T+1: resp_valid=1, resp_data=0, resp_err=0.
- strobe_wr and resp_valid are exactly one cycle wide. addr_wr/data_wr hold their last value after the strobe.
- Read after write: the next request cannot be accepted before T+2, so it always sees the updated local value.
- Reset asserted while in BUSY: the pending response and strobe are cancelled (forced to 0 at that edge); no partial effects remain.
- req_be all zero on a local write: the register is unchanged, but the strobe and response are still issued.
- Inputs other than req_valid are don't-care when req_valid=0.
- debugbus = {state, req_valid, req_ready, req_write, resp_valid, resp_err, strobe_wr, addr_wr[2:0], data_wr[5:0]}.

Test Plan:
- Reset sequence: hold reset low 3 cycles with req_valid=1, then release. Required: no response during reset; local_regs all 0; req_ready=1 in the first cycle after release.
- Read RO word: ro_bundle word 2 = 0x00000ABC, read addr 2 at T. Required: resp_valid=1 at T+1 only, resp_data=0x00000ABC, resp_err=0; req_ready=0 at T+1.
- Local byte-masked write: write addr 51, data 0xDEADBEEF, be=4'b0101 (reg previously 0). Required: local reg 1 = 0x00AD00EF; at T+1 strobe_wr=1, addr_wr=51, data_wr=0xDEADBEEF. A read at T+2 returns 0x00AD00EF.
- Unmapped read: read addr 45 and addr 58. Required: resp_data=0xFFFFFFFF, resp_err=1 for each.
- Back-to-back with req_valid held high: alternate write addr 50 = 0x12345678 and read addr 50. Required: accepts on every second cycle; the read returns 0x12345678.
- Reset mid-transaction: write addr 52 accepted at T, reset low at T+1. Required: strobe_wr=0 and resp_valid=0 after the T+1 edge; local reg 2 = RESET_VAL.
